// File: rtl/if_prefetch.sv
// Instruction prefetch unit: pipelined in-order fetch over req/gnt/rvalid into a
// DEPTH-entry {pc, inst} FIFO. Redirects flush the FIFO and drop in-flight responses.
module if_prefetch #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_addr_i,
  output logic            inst_req_o,
  output logic [XLEN-1:0] inst_addr_o,
  input  logic            inst_gnt_i,
  input  logic            inst_rvalid_i,
  input  logic [XLEN-1:0] inst_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            inst_ready_i
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  // Wide enough to hold count + outstanding without overflow.
  localparam int unsigned CNT_W = $clog2(2 * DEPTH + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PTR_W-1:0] ptr_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] WORD_STEP  = {{(XLEN-3){1'b0}}, 3'd4};
  localparam ptr_t            PTR_ONE    = ptr_t'(1);
  localparam cnt_t            CNT_ONE    = cnt_t'(1);

  logic [XLEN-1:0] fetch_addr;
  cnt_t            outstanding;
  cnt_t            drop_cnt;
  cnt_t            count;
  ptr_t            rd_ptr;
  ptr_t            wr_ptr;
  ptr_t            pcq_rd;
  ptr_t            pcq_wr;

  logic [XLEN-1:0] fifo_pc   [DEPTH];
  logic [XLEN-1:0] fifo_inst [DEPTH];
  logic [XLEN-1:0] pcq       [DEPTH];   // PCs of granted requests, in issue order

  logic accept;
  logic drop_resp;
  logic push;
  logic pop;
  cnt_t credit_used;
  cnt_t outstanding_next;
  cnt_t drop_cnt_next;
  cnt_t count_next;

  // Credit covers entries already buffered plus every response that will still land.
  assign credit_used = count + outstanding - drop_cnt;
  assign inst_req_o  = !rst && !branch_i
                    && (outstanding < cnt_t'(MAX_OUTSTANDING))
                    && (credit_used < cnt_t'(DEPTH));
  assign inst_addr_o = fetch_addr;

  assign accept    = inst_req_o && inst_gnt_i;
  assign drop_resp = (drop_cnt != '0);
  assign push      = inst_rvalid_i && !drop_resp && !branch_i;
  assign pop       = inst_valid_o && inst_ready_i && !branch_i;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    outstanding_next = outstanding + cnt_t'(accept) - cnt_t'(inst_rvalid_i);
    drop_cnt_next    = drop_cnt;
    count_next       = count + cnt_t'(push) - cnt_t'(pop);
    if (branch_i) begin
      // Everything still in flight after this cycle's response belongs to the old path.
      drop_cnt_next = outstanding - cnt_t'(inst_rvalid_i);
      count_next    = '0;
    end else if (inst_rvalid_i && drop_resp) begin
      drop_cnt_next = drop_cnt - CNT_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr  <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pcq_rd      <= '0;
      pcq_wr      <= '0;
    end else begin
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;
      count       <= count_next;

      if (branch_i)    fetch_addr <= branch_addr_i & ALIGN_MASK;
      else if (accept) fetch_addr <= fetch_addr + WORD_STEP;

      if (accept)        pcq_wr <= pcq_wr + PTR_ONE;
      if (inst_rvalid_i) pcq_rd <= pcq_rd + PTR_ONE;
      if (push)          wr_ptr <= wr_ptr + PTR_ONE;

      if (branch_i) rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage arrays are not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (accept) pcq[pcq_wr] <= fetch_addr;
    if (push && !rst) begin
      fifo_pc[wr_ptr]   <= pcq[pcq_rd];
      fifo_inst[wr_ptr] <= inst_rdata_i;
    end
  end

  // Head is masked when empty so outputs read zero out of reset.
  assign inst_valid_o = (count != '0);
  assign inst_o       = inst_valid_o ? fifo_inst[rd_ptr] : '0;
  assign pc_o         = inst_valid_o ? fifo_pc[rd_ptr]   : '0;

endmodule

// File: tb/tb_if_prefetch.sv
// Randomized bench for if_prefetch: an epoch-tagged memory/FIFO scoreboard predicts
// request issue, addresses and the decode-side {pc, inst} stream every cycle.
module tb_if_prefetch;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_gnt_i = 1'b0;
  logic        inst_rvalid_i = 1'b0;
  logic [31:0] inst_rdata_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_ready_i = 1'b0;

  if_prefetch #(
    .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
    .inst_gnt_i(inst_gnt_i), .inst_rvalid_i(inst_rvalid_i), .inst_rdata_i(inst_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_o(pc_o),
    .inst_ready_i(inst_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } entry_t;
  typedef struct { logic [31:0] pc; int epoch; int due; } pend_t;

  entry_t      fifo_q[$];
  pend_t       pend_q[$];
  int          epoch     = 0;
  int          cyc       = 0;
  int          grants    = 0;
  logic [31:0] next_addr = RESET_PC;
  bit          prev_rst  = 1'b0;

  int p_gnt = 100, p_ready = 100, p_rvalid = 100, max_lat = 1;
  int checks = 0, failures = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs at negedge, check outputs, advance the reference model.
  task automatic step(input bit do_rst, input bit do_branch, input logic [31:0] target);
    bit     resp;
    bit     exp_req;
    int     live;
    pend_t  p;
    entry_t e;
    @(negedge clk);
    rst           = do_rst;
    branch_i      = do_branch;
    branch_addr_i = target;
    inst_gnt_i    = ($urandom_range(99) < p_gnt);
    inst_ready_i  = ($urandom_range(99) < p_ready);
    resp = !do_rst && pend_q.size() > 0 && pend_q[0].due <= cyc
           && ($urandom_range(99) < p_rvalid);
    inst_rvalid_i = resp;
    inst_rdata_i  = resp ? mem_word(pend_q[0].pc) : $urandom();
    #1;
    if (do_rst) begin
      check("req_in_rst", {31'd0, inst_req_o}, 32'd0);
      pend_q.delete();
      fifo_q.delete();
      epoch++;
      next_addr = RESET_PC;
    end else begin
      if (prev_rst) begin
        check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("rst_inst", inst_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);
      end
      live = 0;
      foreach (pend_q[i]) if (pend_q[i].epoch == epoch) live++;
      exp_req = !do_branch && pend_q.size() < MAX_OUT && (fifo_q.size() + live) < DEPTH;
      check("req", {31'd0, inst_req_o}, {31'd0, exp_req});
      if (exp_req) check("addr", inst_addr_o, next_addr);
      check("valid", {31'd0, inst_valid_o}, {31'd0, fifo_q.size() != 0});
      if (fifo_q.size() != 0) begin
        check("pc", pc_o, fifo_q[0].pc);
        check("inst", inst_o, fifo_q[0].inst);
      end

      if (resp) p = pend_q.pop_front();
      if (do_branch) begin
        fifo_q.delete();
        epoch++;
        next_addr = target & 32'hFFFF_FFFC;
      end else begin
        if (fifo_q.size() != 0 && inst_ready_i) void'(fifo_q.pop_front());
        if (resp && p.epoch == epoch) begin
          e.pc   = p.pc;
          e.inst = mem_word(p.pc);
          fifo_q.push_back(e);
        end
      end
      if (exp_req && inst_gnt_i) begin
        p.pc    = next_addr;
        p.epoch = epoch;
        p.due   = cyc + $urandom_range(max_lat, 1);
        pend_q.push_back(p);
        next_addr += 32'd4;
        grants++;
      end
    end
    prev_rst = do_rst;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  task automatic knobs(input int g, input int r, input int v, input int l);
    p_gnt = g; p_ready = r; p_rvalid = v; max_lat = l;
  endtask

  initial begin
    logic [31:0] tgt;

    // Full-rate stream: one grant per cycle, one-cycle memory, decode always ready.
    knobs(100, 100, 100, 1);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    run(20);

    // Decode stalled: credit caps grants at DEPTH, then fetch resumes losslessly.
    step(1'b1, 1'b0, '0);
    knobs(100, 0, 100, 1);
    grants = 0;
    run(12);
    check("stall_grants", grants, 32'd4);
    knobs(100, 100, 100, 1);
    run(12);

    // Grant withheld three cycles: address must hold.
    knobs(0, 100, 100, 1);
    run(3);
    knobs(100, 100, 100, 1);
    run(6);

    // Two requests in flight, then a misaligned redirect drops both.
    step(1'b1, 1'b0, '0);
    knobs(100, 100, 0, 1);
    run(4);
    step(1'b0, 1'b1, 32'h0000_0103);
    knobs(100, 100, 100, 1);
    run(10);

    // Redirect coinciding with a response and a pop.
    run(5);
    step(1'b0, 1'b1, 32'h0000_0200);
    run(8);

    // Reset with FIFO full and requests outstanding.
    knobs(100, 0, 100, 2);
    run(10);
    step(1'b1, 1'b0, '0);
    knobs(100, 100, 100, 1);
    run(6);

    // Randomized traffic with redirects, address wrap and occasional resets.
    knobs(70, 60, 70, 3);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99) == 0) begin
        step(1'b1, 1'b0, '0);
      end else if ($urandom_range(99) < 5) begin
        tgt = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                       : ($urandom() & 32'h0000_0FFF);
        step(1'b0, 1'b1, tgt);
      end else begin
        step(1'b0, 1'b0, '0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
Parametrised instruction-fetch unit that replaces the single-cycle core's combinational PC/instruction-memory path. It issues pipelined, in-order requests to a wait-stated instruction memory over a req/gnt/rvalid handshake and buffers returned words with their PCs in a DEPTH-entry FIFO. It presents them to decode with a valid/ready handshake. A branch redirect flushes the FIFO and discards any responses still in flight.

Parameters:
XLEN, 32, address/instruction width
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
MAX_OUTSTANDING, 2, max granted-but-unanswered requests (1..DEPTH)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
branch_i  in  1  redirect request from ID
branch_addr_i  in  XLEN  redirect target
inst_req_o  out  1  memory request
inst_addr_o  out  XLEN  request address, word aligned
inst_gnt_i  in  1  request accepted this cycle
inst_rvalid_i  in  1  response data valid
inst_rdata_i  in  XLEN  response instruction
inst_valid_o  out  1  FIFO head valid
inst_o  out  XLEN  FIFO head instruction
pc_o  out  XLEN  FIFO head PC
inst_ready_i  in  1  decode consumes head

Behaviour:
- Reset: inst_req_o=0, inst_valid_o=0, inst_o=0, pc_o=0. Fetch address=RESET_PC. FIFO count, outstanding count and drop count=0. Reset wins over all other inputs in the same cycle, including mid-transaction. Responses arriving after reset for pre-reset requests are not tracked; the memory is reset together with the core.
- State: fetch_addr, outstanding (0..MAX_OUTSTANDING), drop_cnt (0..MAX_OUTSTANDING), FIFO storing {pc, inst}, count 0..DEPTH.
- Issue condition: inst_req_o = !branch_i && outstanding < MAX_OUTSTANDING && (count + outstanding - drop_cnt) < DEPTH. This credit rule guarantees every non-dropped response has a free slot, so the FIFO never overflows.
- inst_addr_o = fetch_addr; stays stable while inst_req_o && !inst_gnt_i.
- Accept on inst_req_o && inst_gnt_i: fetch_addr += 4 (wraps modulo 2^XLEN), outstanding += 1. The PC of each request is queued internally in issue order, DEPTH-deep.
- Response: inst_rvalid_i arrives at least 1 cycle after its grant, in order. Each response decrements outstanding.
  - If drop_cnt>0, the word is discarded and drop_cnt decrements.
  - Otherwise {issued pc, inst_rdata_i} is pushed to the FIFO.
  - Accept and response in the same cycle: outstanding is unchanged net.
- Output: inst_valid_o = (count != 0); inst_o/pc_o = head entry. Pop on inst_valid_o && inst_ready_i. Push and pop in the same cycle leave count unchanged.
- Latency: grant at cycle t, rvalid at t+k; inst_valid_o rises at t+k+1 (registered FIFO, no bypass).
- Redirect (branch_i=1, no rst):
  - inst_req_o forced 0 that cycle.
  - fetch_addr <= {branch_addr_i[XLEN-1:2], 2'b00}.
  - FIFO count <= 0; any pop that cycle is ignored.
  - A response in the same cycle is discarded.
  - drop_cnt <= outstanding - (inst_rvalid_i ? 1 : 0) + drop_cnt adjustment, i.e. all still-outstanding requests become drops.
  - Outstanding bookkeeping continues normally.
  - inst_valid_o=0 from the next cycle. The first new request issues the cycle after branch_i, if credit allows.
- Back-to-back redirects: the last one defines fetch_addr; drops accumulate, capped by the outstanding count.
- No errors or exceptions are produced. Misaligned redirect targets are silently aligned.

Test Plan:
- Reset, then gnt=1 always and rvalid one cycle after each grant, ready=1 -> addresses 0,4,8,… on successive cycles. The first inst_valid_o appears 2 cycles after the first grant, with pc_o=0, followed by a continuous stream at 1/cycle.
- inst_ready_i=0 with DEPTH=4 and MAX_OUTSTANDING=2 -> exactly 4 grants, then inst_req_o stays 0. The FIFO holds PCs 0,4,8,C. Raising ready -> fetch resumes at 0x10 and no entry is lost or duplicated.
- gnt held 0 for 3 cycles -> inst_addr_o stable at its value. Grant on the 4th cycle -> address advances by 4.
- Two requests outstanding (PCs 0x8, 0xC), branch_i with target 0x103 -> both responses are dropped. The first issued address is 0x100 and the first output has pc_o=0x100.
- branch_i in the same cycle as rvalid and a pop -> that response is discarded, FIFO empty next cycle, drop_cnt equals the remaining outstanding count.
- rst asserted with the FIFO full and requests outstanding -> next cycle all outputs are 0 and inst_addr_o=RESET_PC when a request reissues.
